// File: rtl/mul_div_pkg.sv
// Shared encodings for the iterative multiply/divide stage.
package mul_div_pkg;

  // Operation select as driven by the decoder.
  typedef enum logic [1:0] {
    OP_MUL  = 2'd0,  // signed x signed -> 2W product
    OP_MULU = 2'd1,  // unsigned x unsigned -> 2W product
    OP_DIV  = 2'd2,  // signed dividend / unsigned divisor, floored
    OP_NONE = 2'd3   // reserved, never starts an operation
  } op_e;

  // Control FSM states.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam int DEFAULT_WIDTH = 32;

  // Bits needed for a step counter running 0..w-1.
  function automatic int cnt_width(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit: one shift-add or shift-subtract step per
// cycle over a single shared 2*WIDTH accumulator. Signs are stripped before
// the loop and restored combinationally on the RUN->DONE transition.
module mul_div_unit
  import mul_div_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,      // asynchronous, active-low
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] res_lo,
  output logic [WIDTH-1:0] res_hi
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  state_e             state_q, state_d;
  logic [CW-1:0]      count_q, count_d;
  op_e                op_q, op_d;
  logic               neg_q, neg_d;      // result must be sign-corrected
  logic               dz_q, dz_d;        // divide by zero
  logic [WIDTH-1:0]   opnd_q, opnd_d;    // multiplicand magnitude or divisor
  logic [WIDTH-1:0]   x_q, x_d;          // raw dividend, returned on y==0
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   res_lo_q, res_lo_d;
  logic [WIDTH-1:0]   res_hi_q, res_hi_d;

  op_e                op_in;
  logic               start_ok;
  logic [WIDTH-1:0]   x_abs, y_abs;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_step;
  logic [WIDTH:0]     rem_sh;
  logic               div_ge;
  logic [WIDTH-1:0]   rem_sub;
  logic [2*WIDTH-1:0] div_step;
  logic [2*WIDTH-1:0] step;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   q_raw, r_raw;

  // Operand magnitudes and the datapath step for both operations.
  always_comb begin
    op_in    = op_e'(op);
    start_ok = start && (op_in != OP_NONE);
    // WIDTH-bit negation is exact as an unsigned magnitude, including for
    // the most-negative value (its magnitude is 2^(WIDTH-1)).
    x_abs    = x[WIDTH-1] ? -x : x;
    y_abs    = y[WIDTH-1] ? -y : y;
    // Shift-add: low half holds the remaining multiplier bits, the high
    // half accumulates; the carry out lands in the top bit on the shift.
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opnd_q};
    mul_step = acc_q[0] ? {mul_sum, acc_q[WIDTH-1:1]}
                        : {1'b0, acc_q[2*WIDTH-1:1]};
    // Restoring division: high half is the partial remainder, low half
    // shifts dividend bits out and quotient bits in.
    rem_sh   = acc_q[2*WIDTH-1:WIDTH-1];
    div_ge   = (rem_sh >= {1'b0, opnd_q});
    // rem_sh < 2*divisor, so the difference always fits in WIDTH bits.
    rem_sub  = rem_sh[WIDTH-1:0] - opnd_q;
    div_step = div_ge ? {rem_sub, acc_q[WIDTH-2:0], 1'b1}
                      : {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    step     = (op_q == OP_DIV) ? div_step : mul_step;
    prod     = neg_q ? -step : step;
    q_raw    = step[WIDTH-1:0];
    r_raw    = step[2*WIDTH-1:WIDTH];
  end

  // Next-state, operand capture, iteration and result correction.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    op_d     = op_q;
    neg_d    = neg_q;
    dz_d     = dz_q;
    opnd_d   = opnd_q;
    x_d      = x_q;
    acc_d    = acc_q;
    res_lo_d = res_lo_q;
    res_hi_d = res_hi_q;
    case (state_q)
      S_IDLE: begin
        if (start_ok) begin
          state_d = S_RUN;
          count_d = '0;
          op_d    = op_in;
          x_d     = x;
          dz_d    = 1'b0;
          neg_d   = 1'b0;
          case (op_in)
            OP_MUL: begin
              opnd_d = x_abs;
              acc_d  = {{WIDTH{1'b0}}, y_abs};
              neg_d  = x[WIDTH-1] ^ y[WIDTH-1];
            end
            OP_MULU: begin
              opnd_d = x;
              acc_d  = {{WIDTH{1'b0}}, y};
            end
            default: begin
              opnd_d = y;
              acc_d  = {{WIDTH{1'b0}}, x_abs};
              neg_d  = x[WIDTH-1];
              dz_d   = (y == '0);
            end
          endcase
        end
      end
      S_RUN: begin
        acc_d   = step;
        count_d = count_q + CW'(1);
        if (count_q == LAST_STEP) begin
          state_d = S_DONE;
          if (op_q == OP_DIV) begin
            if (dz_q) begin
              res_lo_d = '1;
              res_hi_d = x_q;
            end else if (neg_q && (r_raw != '0)) begin
              // floor: q = -(q'+1) == ~q', r = y - r'
              res_lo_d = ~q_raw;
              res_hi_d = opnd_q - r_raw;
            end else if (neg_q) begin
              res_lo_d = -q_raw;
              res_hi_d = '0;
            end else begin
              res_lo_d = q_raw;
              res_hi_d = r_raw;
            end
          end else begin
            res_lo_d = prod[WIDTH-1:0];
            res_hi_d = prod[2*WIDTH-1:WIDTH];
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      count_q  <= '0;
      op_q     <= OP_MUL;
      neg_q    <= 1'b0;
      dz_q     <= 1'b0;
      opnd_q   <= '0;
      x_q      <= '0;
      acc_q    <= '0;
      res_lo_q <= '0;
      res_hi_q <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      dz_q     <= dz_d;
      opnd_q   <= opnd_d;
      x_q      <= x_d;
      acc_q    <= acc_d;
      res_lo_q <= res_lo_d;
      res_hi_q <= res_hi_d;
    end
  end

  assign stall  = (state_q == S_IDLE && start_ok) || (state_q == S_RUN);
  assign done   = (state_q == S_DONE);
  assign res_lo = res_lo_q;
  assign res_hi = res_hi_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Testbench for mul_div_unit: directed operations with literal results, plus
// a transaction-level model checked against the outputs on every cycle.
module tb_mul_div_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [1:0]   op = 2'd0;
  logic [W-1:0] x = '0;
  logic [W-1:0] y = '0;
  logic         stall;
  logic         done;
  logic [W-1:0] res_lo;
  logic [W-1:0] res_hi;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  mul_div_unit #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .x      (x),
    .y      (y),
    .stall  (stall),
    .done   (done),
    .res_lo (res_lo),
    .res_hi (res_hi)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, required 0x%08h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference arithmetic straight from the operation definitions.
  function automatic void ref_result(input logic [1:0] o, input logic [W-1:0] a,
                                     input logic [W-1:0] b,
                                     output logic [W-1:0] lo, output logic [W-1:0] hi);
    longint p, xa, yb, q, r;
    logic [63:0] pu;
    if (o == 2'd0) begin
      p  = longint'($signed(a)) * longint'($signed(b));
      lo = p[31:0];
      hi = p[63:32];
    end else if (o == 2'd1) begin
      pu = {32'b0, a} * {32'b0, b};
      lo = pu[31:0];
      hi = pu[63:32];
    end else if (b == '0) begin
      lo = '1;
      hi = a;
    end else begin
      xa = longint'($signed(a));
      yb = longint'({32'b0, b});
      q  = xa / yb;
      r  = xa - q * yb;
      if (r < 0) begin
        q = q - 1;
        r = r + yb;
      end
      lo = q[31:0];
      hi = r[31:0];
    end
  endfunction

  // Transaction model: busy from acceptance until the done cycle ends.
  logic         m_busy = 1'b0;
  logic         m_done = 1'b0;
  int           m_done_at = 0;
  logic [W-1:0] m_lo = '0, m_hi = '0, p_lo = '0, p_hi = '0;

  always @(negedge rst) begin
    m_busy = 1'b0;
    m_done = 1'b0;
    m_lo   = '0;
    m_hi   = '0;
  end

  always @(posedge clk) begin
    logic acc;
    cyc++;
    if (rst) begin
      acc = !m_busy && start && (op != 2'd3);
      if (m_done) begin
        m_done = 1'b0;
        m_busy = 1'b0;
      end else if (m_busy && cyc == m_done_at) begin
        m_done = 1'b1;
        m_lo   = p_lo;
        m_hi   = p_hi;
      end
      if (acc) begin
        m_busy    = 1'b1;
        m_done_at = cyc + W;
        ref_result(op, x, y, p_lo, p_hi);
      end
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    logic es;
    es = (!m_busy && start && (op != 2'd3)) || (m_busy && !m_done);
    check("stall", {31'b0, stall}, {31'b0, es});
    check("done", {31'b0, done}, {31'b0, m_done});
    check("res_lo", res_lo, m_lo);
    check("res_hi", res_hi, m_hi);
  end

  // Issue one operation, wait for done (bounded), check literal results.
  task automatic run_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] e_lo, input logic [W-1:0] e_hi, input bit noise);
    int n, stalls;
    bit got;
    @(posedge clk); #1;
    start = 1'b1; op = o; x = a; y = b;
    n = 0; stalls = 0; got = 0;
    while (n < 120 && !got) begin
      @(negedge clk);
      if (stall) stalls++;
      if (done) begin
        got = 1;
      end else begin
        @(posedge clk); #1;
        n++;
        if (noise && n >= 3 && n <= 8) begin
          start = 1'b1;
          op    = 2'($urandom_range(0, 3));
          x     = $urandom;
          y     = $urandom;
        end else begin
          start = 1'b0;
        end
      end
    end
    if (!got) begin
      n_cmp++;
      n_err++;
      $display("FAIL timeout: no done within %0d cycles (op=%0d)", n, o);
    end else begin
      $display("op=%0d x=0x%08h y=0x%08h -> lo=0x%08h hi=0x%08h latency=%0d stall_cycles=%0d",
               o, a, b, res_lo, res_hi, n, stalls);
      check("latency", W'(n), W'(W + 1));
      check("stall_cycles", W'(stalls), W'(W + 1));
      check("lit_lo", res_lo, e_lo);
      check("lit_hi", res_hi, e_hi);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("reset_done", {31'b0, done}, 32'd0);
    check("reset_stall", {31'b0, stall}, 32'd0);
    check("reset_lo", res_lo, 32'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    run_op(2'd0, 32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFF1, 32'hFFFF_FFFF, 0);
    run_op(2'd1, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFE, 32'h0000_0001, 0);
    run_op(2'd2, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFC, 32'h0000_0001, 0);
    run_op(2'd2, 32'd7,         32'd2,         32'h0000_0003, 32'h0000_0001, 0);
    run_op(2'd2, 32'h1234_5678, 32'd0,         32'hFFFF_FFFF, 32'h1234_5678, 0);
    run_op(2'd2, 32'h8000_0000, 32'd3,         32'hD555_5555, 32'h0000_0001, 0);
    run_op(2'd0, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 32'h4000_0000, 0);
    run_op(2'd2, 32'hFFFF_FFF8, 32'd2,         32'hFFFF_FFFC, 32'h0000_0000, 0);
    run_op(2'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0);
    run_op(2'd1, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 32'h0000_0001, 1);

    // Reserved op: no stall, no operation.
    @(posedge clk); #1;
    start = 1'b1; op = 2'd3; x = 32'd9; y = 32'd9;
    repeat (3) begin
      @(negedge clk);
      check("op3_stall", {31'b0, stall}, 32'd0);
    end
    @(posedge clk); #1;
    start = 1'b0;

    // Reset in the middle of an operation (counter at 10).
    @(posedge clk); #1;
    start = 1'b1; op = 2'd1; x = 32'd100; y = 32'd100;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("rst_stall", {31'b0, stall}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_lo", res_lo, 32'd0);
    check("rst_hi", res_hi, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    run_op(2'd0, 32'd7, 32'hFFFF_FFFA, 32'hFFFF_FFD6, 32'hFFFF_FFFF, 0);

    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
